// File: rtl/restore_stream_unpack_if.sv
// Stream-in / write-port-out bundle for the state-restore unpacker.
// slave is the unpacker's view; master is the producer/consumer view.
interface restore_stream_unpack_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    input  wr_addr, wr_data, wr_valid,
    output wr_ready
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    output wr_addr, wr_data, wr_valid,
    input  wr_ready
  );
endinterface

// File: rtl/restore_stream_unpack.sv
// Splits an address/data word stream into write pairs, buffers them in a
// show-ahead FIFO and drains them to the CPU restore write port.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_ADDR | next accepted word is an address (header); always ready
//   S_DATA | next accepted word is data; pushes {cur_addr, data} pair
module restore_stream_unpack #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  restore_stream_unpack_if.slave bus,
  input  logic                   burst_mode,
  output logic [$clog2(DEPTH):0] level,
  output logic                   proto_err,
  input  logic                   err_clr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0]  PTR_ONE = 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);

  typedef enum logic {S_ADDR = 1'b0, S_DATA = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              mode_q, mode_d;
  logic              proto_err_q;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [IDX_W:0]    wr_ptr_q, rd_ptr_q;

  logic full, empty, push, pop, err_set, s_tready;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign pop   = !empty && bus.wr_ready;
  assign level = wr_ptr_q - rd_ptr_q;

  // Parser next-state: address capture, pair push and burst increment.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    mode_d     = mode_q;
    push       = 1'b0;
    err_set    = 1'b0;
    s_tready   = 1'b1;
    unique case (state_q)
      S_ADDR: begin
        s_tready = 1'b1;
        if (bus.s_tvalid) begin
          cur_addr_d = bus.s_tdata[ADDR_W-1:0];
          mode_d     = burst_mode;
          if (bus.s_tlast) err_set = 1'b1;
          else             state_d = S_DATA;
        end
      end
      S_DATA: begin
        // No fall-through: a same-cycle pop does not free a slot while full.
        s_tready = !full;
        if (bus.s_tvalid && !full) begin
          push = 1'b1;
          if (mode_q) begin
            cur_addr_d = cur_addr_q + STEP;
            if (bus.s_tlast) state_d = S_ADDR;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_ADDR;
    endcase
  end

  // Parser state registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_ADDR;
      cur_addr_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      mode_q     <= mode_d;
    end
  end

  // Sticky protocol error; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)      proto_err_q <= 1'b0;
    else if (err_set) proto_err_q <= 1'b1;
    else if (err_clr) proto_err_q <= 1'b0;
  end

  // FIFO pointers, one bit wider than the index for full/empty detection.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // FIFO storage; entries need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[IDX_W-1:0]] <= cur_addr_q;
      data_mem[wr_ptr_q[IDX_W-1:0]] <= bus.s_tdata;
    end
  end

  assign bus.s_tready = s_tready;
  assign bus.wr_valid = !empty;
  assign bus.wr_addr  = empty ? '0 : addr_mem[rd_ptr_q[IDX_W-1:0]];
  assign bus.wr_data  = empty ? '0 : data_mem[rd_ptr_q[IDX_W-1:0]];
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_restore_stream_unpack.sv
// Directed bench: DEPTH=16 instance for most scenarios, DEPTH=4 instance
// for backpressure; sel steers the shared stimulus to one of them.
module tb_restore_stream_unpack;
  logic clk;
  logic nreset;
  logic sel;
  logic [31:0] s_tdata;
  logic s_tvalid, s_tlast, wr_ready, burst_mode, err_clr;
  int checks = 0;
  int errors = 0;

  restore_stream_unpack_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
  restore_stream_unpack_if #(.DATA_W(32), .ADDR_W(32)) ifb ();

  logic [4:0] level_a;
  logic [2:0] level_b;
  logic perr_a, perr_b;

  restore_stream_unpack #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .ADDR_STEP(4)) dut_a (
    .clk(clk), .nreset(nreset), .bus(ifa.slave), .burst_mode(burst_mode),
    .level(level_a), .proto_err(perr_a), .err_clr(err_clr));

  restore_stream_unpack #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .ADDR_STEP(4)) dut_b (
    .clk(clk), .nreset(nreset), .bus(ifb.slave), .burst_mode(burst_mode),
    .level(level_b), .proto_err(perr_b), .err_clr(err_clr));

  assign ifa.s_tdata  = s_tdata;
  assign ifa.s_tlast  = s_tlast;
  assign ifa.s_tvalid = s_tvalid & ~sel;
  assign ifa.wr_ready = wr_ready & ~sel;
  assign ifb.s_tdata  = s_tdata;
  assign ifb.s_tlast  = s_tlast;
  assign ifb.s_tvalid = s_tvalid & sel;
  assign ifb.wr_ready = wr_ready & sel;

  logic        s_tready_m, wr_valid_m, perr_m;
  logic [31:0] wr_addr_m, wr_data_m;
  logic [4:0]  level_m;
  assign s_tready_m = sel ? ifb.s_tready : ifa.s_tready;
  assign wr_valid_m = sel ? ifb.wr_valid : ifa.wr_valid;
  assign wr_addr_m  = sel ? ifb.wr_addr  : ifa.wr_addr;
  assign wr_data_m  = sel ? ifb.wr_data  : ifa.wr_data;
  assign level_m    = sel ? {2'b00, level_b} : level_a;
  assign perr_m     = sel ? perr_b : perr_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word from a negedge until accepted; returns on a negedge.
  task automatic send_word(input logic [31:0] d, input logic last);
    bit done = 1'b0;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      done = s_tready_m;
      @(posedge clk); @(negedge clk);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL send_timeout word=%h not accepted", d); end
  endtask

  task automatic test_reset;
    nreset = 1'b0; sel = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    wr_ready = 1'b0; burst_mode = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_valid_m !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid_m); end
    checks++; if (level_m !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_m); end
    checks++; if (perr_m !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%b exp=0", perr_m); end
    checks++; if (s_tready_m !== 1'b1) begin errors++; $display("FAIL reset_s_tready got=%b exp=1", s_tready_m); end
    checks++; if (wr_addr_m !== 32'h0 || wr_data_m !== 32'h0) begin
      errors++; $display("FAIL reset_head got=%h/%h exp=0/0", wr_addr_m, wr_data_m); end
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pair;
    sel = 1'b0; burst_mode = 1'b0; wr_ready = 1'b0;
    send_word(32'h8000_0000, 1'b0);
    send_word(32'hDEAD_BEAF, 1'b0);
    checks++; if (level_m !== 5'd1 || wr_valid_m !== 1'b1) begin
      errors++; $display("FAIL pair_latency got level=%0d valid=%b exp 1/1", level_m, wr_valid_m); end
    for (int i = 1; i < 4; i++) begin
      send_word(32'h8000_0000 + i, 1'b0);
      send_word(32'hDEAD_BEAF + i, 1'b0);
    end
    checks++; if (level_m !== 5'd4) begin errors++; $display("FAIL pair_level got=%0d exp=4", level_m); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_valid_m !== 1'b1 || wr_addr_m !== 32'h8000_0000 + i || wr_data_m !== 32'hDEAD_BEAF + i) begin
        errors++; $display("FAIL pair_pop%0d got=%b %h/%h exp=1 %h/%h", i, wr_valid_m, wr_addr_m, wr_data_m,
                           32'h8000_0000 + i, 32'hDEAD_BEAF + i); end
      wr_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    wr_ready = 1'b0;
    checks++; if (wr_valid_m !== 1'b0 || level_m !== 5'd0) begin
      errors++; $display("FAIL pair_empty got valid=%b level=%0d exp 0/0", wr_valid_m, level_m); end
  endtask

  task automatic test_burst;
    sel = 1'b0; burst_mode = 1'b1; wr_ready = 1'b0;
    send_word(32'h2000_0000, 1'b0);
    burst_mode = 1'b0;  // must be ignored until the next header
    for (int i = 0; i < 5; i++) send_word(32'hDEAD_BEAF + i, (i == 4));
    checks++; if (level_m !== 5'd5) begin errors++; $display("FAIL burst_level got=%0d exp=5", level_m); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_valid_m !== 1'b1 || wr_addr_m !== 32'h2000_0000 + 4 * i || wr_data_m !== 32'hDEAD_BEAF + i) begin
        errors++; $display("FAIL burst_pop%0d got=%b %h/%h exp=1 %h/%h", i, wr_valid_m, wr_addr_m, wr_data_m,
                           32'h2000_0000 + 4 * i, 32'hDEAD_BEAF + i); end
      wr_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    wr_ready = 1'b0;
    send_word(32'h3000_0000, 1'b0);
    send_word(32'h1111_1111, 1'b0);
    checks++; if (level_m !== 5'd1 || wr_addr_m !== 32'h3000_0000 || wr_data_m !== 32'h1111_1111) begin
      errors++; $display("FAIL burst_end_state got level=%0d %h/%h exp 1 30000000/11111111",
                         level_m, wr_addr_m, wr_data_m); end
    wr_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    sel = 1'b1; burst_mode = 1'b1; wr_ready = 1'b0;
    @(negedge clk);
    send_word(32'h4000_0000, 1'b0);
    for (int i = 1; i <= 4; i++) send_word(32'hA000_0000 + i, 1'b0);
    checks++; if (level_m !== 5'd4 || s_tready_m !== 1'b0) begin
      errors++; $display("FAIL bp_full got level=%0d ready=%b exp 4/0", level_m, s_tready_m); end
    s_tdata = 32'hA000_0005; s_tlast = 1'b0; s_tvalid = 1'b1; wr_ready = 1'b1;
    #1;
    checks++; if (s_tready_m !== 1'b0 || wr_addr_m !== 32'h4000_0000 || wr_data_m !== 32'hA000_0001) begin
      errors++; $display("FAIL bp_no_bypass got ready=%b %h/%h exp 0 40000000/a0000001",
                         s_tready_m, wr_addr_m, wr_data_m); end
    @(posedge clk); @(negedge clk);
    wr_ready = 1'b0;
    #1;
    checks++; if (level_m !== 5'd3 || s_tready_m !== 1'b1 || wr_addr_m !== 32'h4000_0004) begin
      errors++; $display("FAIL bp_one_pop got level=%0d ready=%b addr=%h exp 3/1/40000004",
                         level_m, s_tready_m, wr_addr_m); end
    @(posedge clk); @(negedge clk);
    s_tvalid = 1'b0;
    checks++; if (level_m !== 5'd4 || s_tready_m !== 1'b0) begin
      errors++; $display("FAIL bp_refill got level=%0d ready=%b exp 4/0", level_m, s_tready_m); end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (wr_addr_m !== 32'h4000_0000 + 4 * i || wr_data_m !== 32'hA000_0001 + i) begin
        errors++; $display("FAIL bp_pop%0d got=%h/%h exp=%h/%h", i, wr_addr_m, wr_data_m,
                           32'h4000_0000 + 4 * i, 32'hA000_0001 + i); end
      wr_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    wr_ready = 1'b0;
    send_word(32'hA000_0006, 1'b1);
    checks++; if (level_m !== 5'd1 || wr_addr_m !== 32'h4000_0014 || wr_data_m !== 32'hA000_0006) begin
      errors++; $display("FAIL bp_last got level=%0d %h/%h exp 1 40000014/a0000006",
                         level_m, wr_addr_m, wr_data_m); end
    wr_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_ready = 1'b0;
    checks++; if (wr_valid_m !== 1'b0) begin errors++; $display("FAIL bp_drained got valid=%b exp=0", wr_valid_m); end
    sel = 1'b0;
    burst_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_proto_err;
    sel = 1'b0; burst_mode = 1'b0; wr_ready = 1'b0;
    send_word(32'h5555_5555, 1'b1);
    checks++; if (perr_m !== 1'b1 || level_m !== 5'd0) begin
      errors++; $display("FAIL perr_set got err=%b level=%0d exp 1/0", perr_m, level_m); end
    send_word(32'h6000_0000, 1'b0);
    send_word(32'h7777_7777, 1'b0);
    checks++; if (level_m !== 5'd1 || wr_addr_m !== 32'h6000_0000 || wr_data_m !== 32'h7777_7777 || perr_m !== 1'b1) begin
      errors++; $display("FAIL perr_resync got level=%0d %h/%h err=%b exp 1 60000000/77777777 1",
                         level_m, wr_addr_m, wr_data_m, perr_m); end
    wr_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_ready = 1'b0;
    err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    checks++; if (perr_m !== 1'b0) begin errors++; $display("FAIL perr_clear got=%b exp=0", perr_m); end
    err_clr = 1'b1;
    send_word(32'h0000_0099, 1'b1);
    err_clr = 1'b0;
    checks++; if (perr_m !== 1'b1) begin errors++; $display("FAIL perr_set_wins got=%b exp=1", perr_m); end
    err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_wrap;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    sel = 1'b0; burst_mode = 1'b1; wr_ready = 1'b0;
    send_word(32'hFFFF_FFF8, 1'b0);
    for (int i = 0; i < 3; i++) send_word(32'hD000_0000 + i, (i == 2));
    burst_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_valid_m !== 1'b1 || wr_addr_m !== exp_a[i] || wr_data_m !== 32'hD000_0000 + i) begin
        errors++; $display("FAIL wrap_pop%0d got=%b %h/%h exp=1 %h/%h", i, wr_valid_m, wr_addr_m, wr_data_m,
                           exp_a[i], 32'hD000_0000 + i); end
      wr_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    wr_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    sel = 1'b0; burst_mode = 1'b1; wr_ready = 1'b0;
    send_word(32'h7000_0000, 1'b0);
    for (int i = 0; i < 3; i++) send_word(32'hC000_0000 + i, 1'b0);
    checks++; if (level_m !== 5'd3) begin errors++; $display("FAIL rst_mid_pre got level=%0d exp=3", level_m); end
    nreset = 1'b0;
    #1;
    checks++; if (wr_valid_m !== 1'b0 || level_m !== 5'd0 || s_tready_m !== 1'b1) begin
      errors++; $display("FAIL rst_mid_async got valid=%b level=%0d ready=%b exp 0/0/1",
                         wr_valid_m, level_m, s_tready_m); end
    @(negedge clk);
    nreset = 1'b1; burst_mode = 1'b0;
    send_word(32'h8000_0010, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    checks++; if (level_m !== 5'd1 || wr_addr_m !== 32'h8000_0010 || wr_data_m !== 32'h1234_5678) begin
      errors++; $display("FAIL rst_mid_resync got level=%0d %h/%h exp 1 80000010/12345678",
                         level_m, wr_addr_m, wr_data_m); end
    wr_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pair();
    test_burst();
    test_backpressure();
    test_proto_err();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
